// File: rtl/divider_pkg.sv
// Shared arithmetic-unit package: FSM state encoding and counter sizing.
// Used by the sequential divider and the multiplier.
package divider_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t FIX  = 2'd2;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done bundle between the control FSM and the divider.
// The FSM is the master; the divider is the slave.
interface seq_divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, div0, quotient, remainder
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, div0, quotient, remainder
  );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
// Combinational; instantiated once by the sequential divider.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic             a_msb,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;

  // r < b holds on entry, so the borrow bit alone decides r_sh >= b.
  always_comb begin
    r_sh   = {r, a_msb};
    diff   = r_sh - {1'b0, b};
    q_bit  = ~diff[WIDTH];
    r_next = q_bit ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
// Fixed latency of WIDTH+2 cycles from accepted start to done.
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x,
    input logic             s
  );
    return (s & x[WIDTH-1]) ? -x : x;
  endfunction

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .a_msb  (a[WIDTH-1]),
    .b      (b),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      a             <= '0;
      b             <= '0;
      r             <= '0;
      q             <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      bus.done      <= 1'b0;
      bus.div0      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              bus.done <= 1'b1;
              bus.div0 <= 1'b1;
            end else begin
              a     <= mag(bus.dividend, bus.signed_op);
              b     <= mag(bus.divisor, bus.signed_op);
              q_neg <= bus.signed_op &
                       (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
              r_neg <= bus.signed_op & bus.dividend[WIDTH-1];
              r     <= '0;
              q     <= '0;
              cnt   <= '0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          a   <= a << 1;
          r   <= r_next;
          q   <= {q[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          // MIN / -1 wraps back to MIN here, as MIPS expects.
          bus.quotient  <= q_neg ? -q : q;
          bus.remainder <= r_neg ? -r : r;
          bus.div0      <= 1'b0;
          bus.done      <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=32 and WIDTH=8.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_seq_divider;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   lat;
  int   bz;

  seq_divider_if #(.WIDTH(32)) bus32 ();
  seq_divider_if #(.WIDTH(8))  bus8 ();

  seq_divider #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go32(input logic s, input logic [31:0] x,
                      input logic [31:0] y);
    bus32.start     = 1'b1;
    bus32.signed_op = s;
    bus32.dividend  = x;
    bus32.divisor   = y;
    @(negedge clk);
    bus32.start = 1'b0;
  endtask

  task automatic go8(input logic s, input logic [7:0] x,
                     input logic [7:0] y);
    bus8.start     = 1'b1;
    bus8.signed_op = s;
    bus8.dividend  = x;
    bus8.divisor   = y;
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  // n0: cycles since the accepting edge at the current falling edge
  task automatic wait32(input int n0, output int l, output int b);
    l = n0;
    b = 0;
    while (bus32.done !== 1'b1 && l < 200) begin
      if (bus32.busy === 1'b1) b++;
      @(negedge clk);
      l++;
    end
    check("done32_timeout", {31'd0, bus32.done}, 32'd1);
  endtask

  task automatic wait8(output int l);
    l = 1;
    while (bus8.done !== 1'b1 && l < 200) begin
      @(negedge clk);
      l++;
    end
    check("done8_timeout", {31'd0, bus8.done}, 32'd1);
  endtask

  task automatic op32(input string tag, input logic s,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eq, input logic [31:0] er);
    go32(s, x, y);
    wait32(1, lat, bz);
    check({tag, "_q"}, bus32.quotient, eq);
    check({tag, "_r"}, bus32.remainder, er);
    check({tag, "_lat"}, lat, 34);
    check({tag, "_div0"}, {31'd0, bus32.div0}, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus32.start = 1'b0; bus32.signed_op = 1'b0;
    bus32.dividend = '0; bus32.divisor = '0;
    bus8.start = 1'b0; bus8.signed_op = 1'b0;
    bus8.dividend = '0; bus8.divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus32.busy}, 32'd0);
    check("rst_done", {31'd0, bus32.done}, 32'd0);
    check("rst_div0", {31'd0, bus32.div0}, 32'd0);
    check("rst_q", bus32.quotient, 32'd0);
    check("rst_r", bus32.remainder, 32'd0);
    check("rst_q8", {24'd0, bus8.quotient}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    go32(1'b0, 32'd100, 32'd7);
    wait32(1, lat, bz);
    check("u100_7_q", bus32.quotient, 32'd14);
    check("u100_7_r", bus32.remainder, 32'd2);
    check("u100_7_lat", lat, 34);
    check("u100_7_busy", bz, 33);
    check("u100_7_div0", {31'd0, bus32.div0}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, bus32.done}, 32'd0);

    op32("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    op32("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    op32("ubig", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);
    op32("u100_7b", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    go32(1'b1, 32'd55, 32'd0);
    check("s_div0_done", {31'd0, bus32.done}, 32'd1);
    check("s_div0_flag", {31'd0, bus32.div0}, 32'd1);
    check("s_div0_q", bus32.quotient, 32'd14);
    check("s_div0_r", bus32.remainder, 32'd2);
    @(negedge clk);
    check("div0_pulse", {31'd0, bus32.done}, 32'd0);
    check("div0_hold", {31'd0, bus32.div0}, 32'd1);
    go32(1'b0, 32'hFFFF_FFFF, 32'd0);
    check("u_div0_done", {31'd0, bus32.done}, 32'd1);
    check("u_div0_flag", {31'd0, bus32.div0}, 32'd1);
    check("u_div0_q", bus32.quotient, 32'd14);
    check("u_div0_r", bus32.remainder, 32'd2);
    @(negedge clk);

    op32("min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

    // Requests and operand changes while busy must not disturb the result.
    go32(1'b0, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    bus32.start = 1'b1; bus32.dividend = 32'd999; bus32.divisor = 32'd0;
    @(negedge clk);
    bus32.start = 1'b0; bus32.divisor = 32'd5;
    wait32(5, lat, bz);
    check("ign_q", bus32.quotient, 32'd14);
    check("ign_r", bus32.remainder, 32'd2);
    check("ign_lat", lat, 34);
    check("ign_div0", {31'd0, bus32.div0}, 32'd0);
    go32(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait32(1, lat, bz);
    check("b2b_q", bus32.quotient, 32'hFFFF_FFFD);
    check("b2b_r", bus32.remainder, 32'hFFFF_FFFF);
    check("b2b_lat", lat, 34);
    @(negedge clk);

    go32(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, bus32.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus32.done}, 32'd0);
    check("mid_rst_div0", {31'd0, bus32.div0}, 32'd0);
    check("mid_rst_q", bus32.quotient, 32'd0);
    check("mid_rst_r", bus32.remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus32.done === 1'b1 || bus32.busy === 1'b1) bz++;
    end
    check("no_done_after_rst", bz, 0);
    op32("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    go8(1'b0, 8'd200, 8'd3);
    wait8(lat);
    check("w8_q", {24'd0, bus8.quotient}, 32'd66);
    check("w8_r", {24'd0, bus8.remainder}, 32'd2);
    check("w8_lat", lat, 10);
    @(negedge clk);
    go8(1'b1, 8'h80, 8'hFF);
    wait8(lat);
    check("w8_min_q", {24'd0, bus8.quotient}, 32'h80);
    check("w8_min_r", {24'd0, bus8.remainder}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
